// File: rtl/alu_mul_sequencer_if.sv
// Bundle between the multiply sequencer, its requester and the shared ALU.
// The slave modport is the sequencer; the master side is the requester plus the ALU.
interface alu_mul_sequencer_if #(
  parameter int OPW = 16
);
  logic           start;
  logic [OPW-1:0] opA;
  logic [OPW-1:0] opB;
  logic           busy;
  logic           done;
  logic           err;
  logic [31:0]    product;
  logic [3:0]     alu_ctrl;
  logic [31:0]    alu_a;
  logic [31:0]    alu_b;
  logic           alu_shiftDir;
  logic           alu_shiftOp;
  logic [31:0]    alu_res;
  logic           alu_carry;

  modport slave (
    input  start, opA, opB, alu_res, alu_carry,
    output busy, done, err, product,
    output alu_ctrl, alu_a, alu_b,
    output alu_shiftDir, alu_shiftOp
  );

  modport master (
    output start, opA, opB, alu_res, alu_carry,
    input  busy, done, err, product,
    input  alu_ctrl, alu_a, alu_b,
    input  alu_shiftDir, alu_shiftOp
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the execute-stage ALU.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier is 0.
module alu_mul_sequencer #(
  parameter int OPW = 16
) (
  input logic                  clk,
  input logic                  rst,
  alu_mul_sequencer_if.slave   bus
);

  localparam int CW = $clog2(OPW) + 1;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SHF = 4'b0100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    p_q, p_d;
  logic [31:0]    m_q, m_d;
  logic [OPW-1:0] q_q, q_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           last;

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Final-iteration detect; early exit stops once no multiplier bits remain.
  always_comb begin
`ifdef MUL_EARLY_EXIT_EN
    last = (cnt_q == CW'(OPW - 1)) || ((q_q >> 1) == '0);
`else
    last = (cnt_q == CW'(OPW - 1));
`endif
  end

  // Next state, register updates and ALU drive for the current state.
  always_comb begin
    state_d          = state_q;
    p_d              = p_q;
    m_d              = m_q;
    q_d              = q_q;
    cnt_d            = cnt_q;
    err_d            = err_q;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    bus.alu_ctrl     = ALU_ADD;
    bus.alu_a        = '0;
    bus.alu_b        = '0;
    bus.alu_shiftDir = 1'b0;
    bus.alu_shiftOp  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          p_d     = '0;
          m_d     = {{(32 - OPW){1'b0}}, bus.opA};
          q_d     = bus.opB;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        bus.busy     = 1'b1;
        bus.alu_ctrl = ALU_ADD;
        bus.alu_a    = p_q;
        bus.alu_b    = q_q[0] ? m_q : 32'd0;
        p_d          = bus.alu_res;
        err_d        = err_q | bus.alu_carry;
        state_d      = S_SHIFT;
      end
      S_SHIFT: begin
        bus.busy     = 1'b1;
        bus.alu_ctrl = ALU_SHF;
        bus.alu_a    = m_q;
        bus.alu_b    = 32'd1;
        m_d          = bus.alu_res;
        q_d          = q_q >> 1;
        cnt_d        = cnt_q + 1'b1;
        state_d      = last ? S_DONE : S_ADD;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.product = p_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer with a behavioural ALU.
// Expected products go into a scoreboard queue and are checked at done.
module tb_alu_mul_sequencer;

  localparam int OPW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inj_c = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [32:0] sb_q[$];

  alu_mul_sequencer_if #(.OPW(OPW)) bus ();

  alu_mul_sequencer #(.OPW(OPW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU with a carry fault injector.
  logic [32:0] sum;
  logic [31:0] res;
  logic        cy;
  always_comb begin
    sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    res = '0;
    cy  = 1'b0;
    case (bus.alu_ctrl)
      4'b0010: begin
        res = sum[31:0];
        cy  = sum[32] | inj_c;
      end
      4'b0100: res = bus.alu_shiftDir ?
                     (bus.alu_a >> bus.alu_b[4:0]) :
                     (bus.alu_a << bus.alu_b[4:0]);
      default: res = '0;
    endcase
  end
  assign bus.alu_res   = res;
  assign bus.alu_carry = cy;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lat(input logic [15:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int h;
    h = 0;
    for (int i = 0; i < OPW; i++)
      if (b[i]) h = i;
    return 2 * (h + 1);
`else
    return 2 * OPW;
`endif
  endfunction

  task automatic run_mul(input logic [15:0] a,
                         input logic [15:0] b,
                         input bit hold,
                         input bit inj);
    int cyc;
    int nbusy;
    int bad;
    bit got;
    logic [32:0] e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.opA   = a;
    bus.opB   = b;
    sb_q.push_back({inj, 32'(a) * 32'(b)});
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    inj_c = inj;
    cyc = 0; nbusy = 0; bad = 0; got = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      if (hold && cyc == 3) begin
        bus.opA = 16'd99;
        bus.opB = 16'd55;
      end
      if (bus.done) begin
        got = 1;
      end else begin
        if (bus.busy) begin
          nbusy++;
          if (cyc % 2 == 0) begin
            if (bus.alu_ctrl !== 4'b0010) bad++;
          end else begin
            if (bus.alu_ctrl !== 4'b0100) bad++;
            if (bus.alu_b !== 32'd1) bad++;
          end
        end
        @(posedge clk);
        #1;
        inj_c = 1'b0;
        cyc++;
      end
    end
    if (!got) begin
      chk("timeout", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    chk("latency", cyc, lat(b));
    chk("busy_cycles", nbusy, lat(b));
    chk("alu_ctrl_seq", bad, 0);
    chk("product", bus.product, e[31:0]);
    chk("err", {31'd0, bus.err}, {31'd0, e[32]});
    @(posedge clk);
    #1;
    chk("done_pulse", {31'd0, bus.done}, 0);
    chk("idle_busy", {31'd0, bus.busy}, 0);
    chk("product_hold", bus.product, e[31:0]);
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.opA   = '0;
    bus.opB   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_err", {31'd0, bus.err}, 0);
    chk("rst_product", bus.product, 0);
    chk("rst_ctrl", {28'd0, bus.alu_ctrl}, 32'h2);
    rst = 1'b0;

    run_mul(16'd7, 16'd19, 0, 0);
    run_mul(16'hFFFF, 16'hFFFF, 0, 0);
    chk("ffff_value", bus.product, 32'hFFFE0001);
    run_mul(16'd13, 16'd17, 1, 0);

    // Reset in the middle of 243 x 117.
    @(negedge clk);
    bus.start = 1'b1;
    bus.opA   = 16'd243;
    bus.opB   = 16'd117;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, bus.busy}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, bus.busy}, 0);
    chk("mid_rst_done", {31'd0, bus.done}, 0);
    chk("mid_rst_product", bus.product, 0);
    chk("mid_rst_alu_a", bus.alu_a, 0);
    run_mul(16'd243, 16'd117, 0, 0);

    run_mul(16'd100, 16'd200, 0, 1);
    run_mul(16'd3, 16'd4, 0, 0);

    run_mul(16'd5, 16'd3, 0, 0);
    run_mul(16'd1234, 16'd0, 0, 0);

    for (int i = 0; i < 4; i++)
      run_mul(16'($urandom), 16'($urandom), 0, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle unsigned multiplier controller that performs shift-and-add multiplication by sequencing the shared ALU through its control and operand ports. It sits beside the ALU in the execute stage. It drives `ALUctrlOP`, `A`, `B`, `shiftDir` and `shiftOp` itself, and latches `ALUres` into internal registers each cycle. The block keeps only the multiplier bit-counter and operand registers; all arithmetic is done by the ALU.

## Interface
Parameters:
- `OPW`, default 16, operand width; product is `2*OPW` bits; legal range 2..16.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `opA`  in  OPW  multiplicand, captured when start is accepted
- `opB`  in  OPW  multiplier, captured when start is accepted
- `busy`  out  1  high in ADD/SHIFT states
- `done`  out  1  one-cycle pulse; high only in DONE state
- `product`  out  32  result; valid from done, held until the next accepted start
- `err`  out  1  sticky; set if `alu_carry`=1 during any ADD; cleared by an accepted start or by reset
- `alu_ctrl`  out  4  drives ALU `ALUctrlOP`
- `alu_a`  out  32  drives ALU `A`
- `alu_b`  out  32  drives ALU `B`
- `alu_shiftDir`  out  1  drives ALU `shiftDir`
- `alu_shiftOp`  out  1  drives ALU `shiftOp`
- `alu_res`  in  32  from ALU `ALUres`
- `alu_carry`  in  1  from ALU `carryFlag`

## Operation
- Internal registers:
  - P: 32-bit accumulator, which is `product`.
  - M: 32-bit multiplicand, zero-extended.
  - Q: OPW-bit multiplier.
  - cnt: iteration counter, clog2(OPW)+1 bits.
- States are IDLE, ADD, SHIFT, DONE.
- IDLE:
  - Outputs `busy`=0 and `done`=0.
  - On `start`=1, load P=0, M={0,opA}, Q=opB, cnt=0, and err=0, then go to ADD.
  - `start`=0 stays in IDLE.
- ADD:
  - Drives `alu_ctrl`=4'b0010 and `alu_a`=P.
  - Drives `alu_b`=M when Q[0]=1, else 0.
  - Latches P←`alu_res` and sets err if `alu_carry`.
  - Next state is SHIFT.
- SHIFT:
  - Drives `alu_ctrl`=4'b0100, `alu_a`=M, `alu_b`=1, `alu_shiftDir`=0 (left) and `alu_shiftOp`=0 (logical).
  - Latches M←`alu_res`, shifts Q right by 1 internally (zero fill), and does cnt+1.
  - Next state is DONE if cnt==OPW-1, else ADD.
- DONE:
  - `done`=1 and `busy`=0.
  - Next state is IDLE unconditionally.
  - `start` is ignored in DONE.
- Idle ALU drive (IDLE/DONE): `alu_ctrl`=4'b0010, `alu_a`=`alu_b`=0, `alu_shiftDir`=`alu_shiftOp`=0.
- `start` while busy or in DONE is ignored, not queued. Operands are not re-sampled.
- Unsigned only. With OPW≤16 the product fits in 32 bits, so `err` indicates an ALU fault, not overflow.

## Timing
- The accepting edge is E0. ADD/SHIFT alternate for 2*OPW cycles, and DONE is entered at edge E(2*OPW).
  - For OPW=16, `done` is high in the cycle following E32, for exactly one cycle.
  - The earliest next accept is at E34.
- `busy` rises at E0 and falls at E(2*OPW).
- The ALU is combinational. Its drive is a function of the current state and registers, and its result is captured at the end of the same cycle. The block inserts no wait states.
- `product` changes only at ADD edges and at accept (cleared to 0); otherwise it holds.
- Reset is dominant, including mid-operation. Synchronous `rst`=1 forces all of the following, regardless of `start`:
  - state=IDLE
  - P=0, M=0, Q=0, cnt=0
  - `busy`=0, `done`=0, `err`=0
  - idle ALU drive

## Configuration
- `MUL_EARLY_EXIT_EN` defined:
  - In SHIFT, if the post-shift Q==0, the next state is DONE regardless of cnt.
  - Latency becomes 2*(index of highest set bit of opB + 1) cycles to DONE entry.
  - opB=0 yields 2 cycles: one ADD of 0, then one SHIFT.
- Undefined: latency is fixed at 2*OPW cycles for all operands.
- The product value is identical in both builds.

## Test plan
- OPW=16, opA=7, opB=19, start pulse → `done` high for one cycle at E32, `product`=133, `err`=0, `busy` high for exactly 32 cycles.
- opA=16'hFFFF, opB=16'hFFFF → `product`=32'hFFFE0001. During every ADD cycle `alu_ctrl`=4'b0010; during every SHIFT cycle `alu_ctrl`=4'b0100 and `alu_b`=1.
- Start 13×17. Hold `start`=1 continuously and also present new operands mid-run → the result is 221, and no second run starts before E34. Only one `done` pulse occurs per accept.
- Start 243×117, then assert `rst` at E10 → in the next cycle state is IDLE, `busy`=0, `product`=0. A new start of 243×117 then yields 28431.
- Force `alu_carry`=1 for one ADD cycle → `err`=1 and held through `done`. It is cleared by the next accepted start.
- With `MUL_EARLY_EXIT_EN`:
  - opA=5, opB=3 → DONE entered at E4, `product`=15.
  - opB=0 → DONE at E2, `product`=0.
- Without the macro, both cases → DONE at E32.
